// File: rtl/maze_pkg.sv
// Shared types for the maze explorer: move directions, FSM states and
// the direction inversion used when unwinding the path.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_XM = 2'd0,
        DIR_YP = 2'd1,
        DIR_YM = 2'd2,
        DIR_XP = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        TRY,
        WAIT,
        BACKTRACK,
        REPLAY,
        DONE,
        FAIL
    } state_t;

    // Encoding is chosen so that the opposite direction is the bitwise inverse.
    function automatic dir_t inv_dir(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/path_stack.sv
// LIFO of moves taken on the forward path, with a separate indexed read
// port so the finished path can be streamed out bottom-first.
module path_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int SW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  dir_t          din,
    output dir_t          top,
    output logic [SW-1:0] sp,
    output logic          full,
    output logic          empty,
    input  logic [SW-1:0] rd_idx,
    output dir_t          rd_data
);

    dir_t          mem [DEPTH];
    logic [SW-1:0] sp_m1;

    assign sp_m1   = sp - SW'(1);
    assign full    = (sp == SW'(DEPTH));
    assign empty   = (sp == '0);
    assign top     = mem[sp_m1[AW-1:0]];
    assign rd_data = (rd_idx < SW'(DEPTH)) ? mem[rd_idx[AW-1:0]] : DIR_XM;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SW'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rat_maze_explorer.sv
// Depth-first maze walker from (0,0) to the all-ones corner, probing an
// external wall memory and replaying the found path as a move stream.
//
// state     | meaning
// IDLE      | after reset, all outputs low
// TRY       | pick next direction from current cell, skip or probe it
// WAIT      | wall result for the probed neighbour arrives
// BACKTRACK | cell exhausted, step back along the popped move
// REPLAY    | stream stored path, one move per accepted handshake
// DONE      | path delivered, position held at goal
// FAIL      | no path, or path longer than the stack
module rat_maze_explorer
    import maze_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               replay,
    output logic               rd_req,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic               wall,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               move_valid,
    output logic [1:0]         move,
    input  logic               move_ready,
    output logic               busy,
    output logic               done,
    output logic               fail
);

    localparam int SW    = $clog2(DEPTH + 1);
    localparam int NCELL = 1 << (2 * COORD_W);

    state_t             state, state_nxt;
    logic [2:0]         dir;
    logic [NCELL-1:0]   visited;
    logic [SW-1:0]      rp, sp;
    logic [COORD_W-1:0] nb_x, nb_y;
    dir_t               step_dir, stk_top, rd_data;
    logic               oob, nb_vis, at_goal, full, empty;
    logic               start_run, do_push, do_pop, dir_inc, rp_clr, rp_inc;
    logic               probe, mv;

    // One stepper serves both the forward probe and the backtrack move.
    assign step_dir = (state == BACKTRACK) ? inv_dir(stk_top) : dir_t'(dir[1:0]);

    always_comb begin
        nb_x = x;
        nb_y = y;
        oob  = 1'b0;
        case (step_dir)
            DIR_XM: begin nb_x = x - COORD_W'(1); oob = (x == '0); end
            DIR_YP: begin nb_y = y + COORD_W'(1); oob = (y == '1); end
            DIR_YM: begin nb_y = y - COORD_W'(1); oob = (y == '0); end
            DIR_XP: begin nb_x = x + COORD_W'(1); oob = (x == '1); end
            default: ;
        endcase
    end

    assign nb_vis  = visited[{nb_y, nb_x}];
    assign at_goal = (nb_x == '1) && (nb_y == '1);

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        dir_inc   = 1'b0;
        rp_clr    = 1'b0;
        rp_inc    = 1'b0;
        probe     = 1'b0;
        mv        = 1'b0;
        case (state)
            IDLE, FAIL: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = TRY;
                end
            end
            TRY: begin
                if (dir[2]) begin
                    state_nxt = BACKTRACK;
                end else if (oob || nb_vis) begin
                    dir_inc = 1'b1;
                end else begin
                    probe     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wall) begin
                    dir_inc   = 1'b1;
                    state_nxt = TRY;
                end else if (full) begin
                    state_nxt = FAIL;
                end else begin
                    do_push = 1'b1;
                    if (at_goal) begin
                        rp_clr    = 1'b1;
                        state_nxt = REPLAY;
                    end else begin
                        state_nxt = TRY;
                    end
                end
            end
            BACKTRACK: begin
                if (empty) begin
                    state_nxt = FAIL;
                end else begin
                    do_pop    = 1'b1;
                    state_nxt = TRY;
                end
            end
            REPLAY: begin
                if (rp == sp) begin
                    state_nxt = DONE;
                end else begin
                    mv     = 1'b1;
                    rp_inc = move_ready;
                end
            end
            DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = TRY;
                end else if (replay) begin
                    rp_clr    = 1'b1;
                    state_nxt = REPLAY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            dir     <= '0;
            visited <= '0;
            rp      <= '0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                x       <= '0;
                y       <= '0;
                dir     <= '0;
                visited <= NCELL'(1);
            end else if (do_push) begin
                x                     <= nb_x;
                y                     <= nb_y;
                dir                   <= '0;
                visited[{nb_y, nb_x}] <= 1'b1;
            end else if (do_pop) begin
                x   <= nb_x;
                y   <= nb_y;
                dir <= {1'b0, stk_top} + 3'd1;
            end else if (dir_inc) begin
                dir <= dir + 3'd1;
            end
            if (rp_clr) begin
                rp <= '0;
            end else if (rp_inc) begin
                rp <= rp + SW'(1);
            end
        end
    end

    path_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_run),
        .push    (do_push),
        .pop     (do_pop),
        .din     (dir_t'(dir[1:0])),
        .top     (stk_top),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .rd_idx  (rp),
        .rd_data (rd_data)
    );

    assign rd_req     = probe;
    assign rd_x       = probe ? nb_x : '0;
    assign rd_y       = probe ? nb_y : '0;
    assign move_valid = mv;
    assign move       = mv ? rd_data : 2'b00;
    assign busy       = (state == TRY) || (state == WAIT) || (state == BACKTRACK) || (state == REPLAY);
    assign done       = (state == DONE);
    assign fail       = (state == FAIL);

endmodule

// File: tb/tb_rat_maze_explorer.sv
// Directed bench for rat_maze_explorer on a 4x4 grid: open maze, stalls,
// replay, reset mid-stream, fully walled start, a backtracking maze and overflow.
module tb_rat_maze_explorer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, replay, move_ready, wall;
    logic       rd_req, move_valid, busy, done, fail;
    logic [1:0] rd_x, rd_y, x, y, move;

    logic       start_s, replay_s, move_ready_s, wall_s;
    logic       rd_req_s, move_valid_s, busy_s, done_s, fail_s;
    logic [1:0] rd_x_s, rd_y_s, x_s, y_s, move_s;

    logic [15:0] blocked;
    int          checks = 0;
    int          errors = 0;
    int          probe_n = 0;
    logic [1:0]  probe_x [256];
    logic [1:0]  probe_y [256];
    int          got [64];
    int          got_n;
    int          exp_open [12] = '{1, 1, 1, 3, 2, 2, 2, 3, 1, 1, 1, 3};
    int          exp_maze [10] = '{1, 1, 3, 2, 2, 3, 1, 1, 1, 3};

    rat_maze_explorer #(.COORD_W(2), .DEPTH(64)) u_main (
        .clk(clk), .rst(rst), .start(start), .replay(replay),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .wall(wall),
        .x(x), .y(y), .move_valid(move_valid), .move(move), .move_ready(move_ready),
        .busy(busy), .done(done), .fail(fail)
    );

    rat_maze_explorer #(.COORD_W(2), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .replay(replay_s),
        .rd_req(rd_req_s), .rd_x(rd_x_s), .rd_y(rd_y_s), .wall(wall_s),
        .x(x_s), .y(y_s), .move_valid(move_valid_s), .move(move_s), .move_ready(move_ready_s),
        .busy(busy_s), .done(done_s), .fail(fail_s)
    );

    // Single-cycle wall memory plus a log of every probed cell.
    always @(posedge clk) begin
        wall <= rd_req ? blocked[{rd_y, rd_x}] : 1'b0;
        if (rd_req) begin
            if (probe_n < 256) begin
                probe_x[probe_n] <= rd_x;
                probe_y[probe_n] <= rd_y;
            end
            probe_n <= probe_n + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!move_valid && !fail && n < 500) begin
            tick;
            n++;
        end
    endtask

    task automatic collect_moves(input int stall_at, input int start_at);
        int stall_left;
        bit stalled, started;
        stall_left = 0;
        stalled    = 0;
        started    = 0;
        got_n      = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            start = 1'b0;
            if (stall_at >= 0 && got_n == stall_at && !stalled) begin
                stalled    = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                move_ready = 1'b0;
                stall_left--;
                checks++;
                if (move_valid !== 1'b1 || move !== 2'd2) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b move=%0d, need valid=1 move=2", move_valid, move);
                end
            end else begin
                move_ready = 1'b1;
            end
            if (start_at >= 0 && got_n == start_at && !started) begin
                start   = 1'b1;
                started = 1;
            end
            if (move_valid && move_ready && got_n < 64) begin
                got[got_n] = int'(move);
                got_n++;
            end
            tick;
        end
        start      = 1'b0;
        move_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; replay = 1'b0; move_ready = 1'b1;
        start_s = 1'b0; replay_s = 1'b0; move_ready_s = 1'b1; wall_s = 1'b0;
        blocked = 16'h0000;
        tick; tick;
        checks++;
        if ({busy, done, fail, move_valid, rd_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_status: got %b, need 00000", {busy, done, fail, move_valid, rd_req});
        end
        checks++;
        if ({x, y, move, rd_x, rd_y} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: x=%0d y=%0d move=%0d rd=%0d,%0d, need all 0", x, y, move, rd_x, rd_y);
        end
        checks++;
        if ({busy_s, done_s, fail_s, x_s, y_s} !== 7'b0) begin
            errors++;
            $display("FAIL reset_small: got %b, need 0", {busy_s, done_s, fail_s, x_s, y_s});
        end
        rst = 1'b1;
        tick;
        checks++;
        if ({busy, done, fail} !== 3'b0) begin
            errors++;
            $display("FAIL idle_hold: busy/done/fail=%b, need 000", {busy, done, fail});
        end
    endtask

    task automatic test_open_run;
        int n, p0, dups;
        blocked = 16'h0000;
        p0 = probe_n;
        start = 1'b1; tick; start = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 45) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d cycles, need 45", n);
        end
        collect_moves(-1, -1);
        checks++;
        if (got_n != 12) begin
            errors++;
            $display("FAIL open_count: got %0d moves, need 12", got_n);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] != exp_open[i]) begin
                errors++;
                $display("FAIL open_move[%0d]: got %0d, need %0d", i, got[i], exp_open[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || x !== 2'd3 || y !== 2'd3) begin
            errors++;
            $display("FAIL open_done: done=%b busy=%b x=%0d y=%0d, need 1 0 3 3", done, busy, x, y);
        end
        checks++;
        if (probe_n - p0 != 12) begin
            errors++;
            $display("FAIL open_probes: got %0d probes, need 12", probe_n - p0);
        end
        dups = 0;
        for (int i = p0; i < probe_n; i++)
            for (int j = i + 1; j < probe_n; j++)
                if (probe_x[i] == probe_x[j] && probe_y[i] == probe_y[j]) dups++;
        checks++;
        if (dups != 0) begin
            errors++;
            $display("FAIL open_revisit: got %0d repeated probes, need 0", dups);
        end
    endtask

    task automatic test_replay;
        replay = 1'b1; tick; replay = 1'b0;
        checks++;
        if (move_valid !== 1'b1 || move !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL replay_first: valid=%b move=%0d busy=%b, need 1 1 1", move_valid, move, busy);
        end
        collect_moves(-1, 4);
        checks++;
        if (got_n != 12 || done !== 1'b1) begin
            errors++;
            $display("FAIL replay_count: got %0d moves done=%b, need 12 moves done=1", got_n, done);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] != exp_open[i]) begin
                errors++;
                $display("FAIL replay_move[%0d]: got %0d, need %0d", i, got[i], exp_open[i]);
            end
        end
    endtask

    task automatic test_stall_and_start_wins;
        int n;
        start = 1'b1; replay = 1'b1; tick; start = 1'b0; replay = 1'b0;
        checks++;
        if (busy !== 1'b1 || move_valid !== 1'b0 || x !== 2'd0 || y !== 2'd0) begin
            errors++;
            $display("FAIL start_wins: busy=%b valid=%b x=%0d y=%0d, need 1 0 0 0", busy, move_valid, x, y);
        end
        wait_valid(n);
        checks++;
        if (n != 45) begin
            errors++;
            $display("FAIL rerun_latency: got %0d cycles, need 45", n);
        end
        collect_moves(5, -1);
        checks++;
        if (got_n != 12) begin
            errors++;
            $display("FAIL stall_count: got %0d moves, need 12", got_n);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] != exp_open[i]) begin
                errors++;
                $display("FAIL stall_move[%0d]: got %0d, need %0d", i, got[i], exp_open[i]);
            end
        end
    endtask

    task automatic test_reset_mid_replay;
        int n;
        replay = 1'b1; tick; replay = 1'b0;
        tick; tick;
        rst = 1'b0; tick;
        checks++;
        if ({busy, done, fail, move_valid} !== 4'b0 || x !== 2'd0 || y !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: busy/done/fail/valid=%b x=%0d y=%0d, need 0000 0 0",
                     {busy, done, fail, move_valid}, x, y);
        end
        rst = 1'b1; tick;
        start = 1'b1; tick; start = 1'b0;
        wait_valid(n);
        collect_moves(-1, -1);
        checks++;
        if (got_n != 12 || done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run: got %0d moves done=%b, need 12 moves done=1", got_n, done);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got[i] != exp_open[i]) begin
                errors++;
                $display("FAIL post_reset_move[%0d]: got %0d, need %0d", i, got[i], exp_open[i]);
            end
        end
    endtask

    task automatic test_wall_all;
        int n, p0, mv_seen;
        blocked = 16'hFFFF;
        p0 = probe_n;
        mv_seen = 0;
        start = 1'b1; tick; start = 1'b0;
        n = 0;
        while (!fail && n < 50) begin
            if (move_valid) mv_seen++;
            tick;
            n++;
        end
        checks++;
        if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || n != 8) begin
            errors++;
            $display("FAIL walled_fail: fail=%b done=%b busy=%b after %0d cycles, need 1 0 0 after 8",
                     fail, done, busy, n);
        end
        checks++;
        if (probe_n - p0 != 2) begin
            errors++;
            $display("FAIL walled_probe_count: got %0d, need 2", probe_n - p0);
        end else begin
            checks++;
            if (probe_x[p0] !== 2'd0 || probe_y[p0] !== 2'd1 || probe_x[p0+1] !== 2'd1 || probe_y[p0+1] !== 2'd0) begin
                errors++;
                $display("FAIL walled_probe_cells: got (%0d,%0d),(%0d,%0d), need (0,1),(1,0)",
                         probe_x[p0], probe_y[p0], probe_x[p0+1], probe_y[p0+1]);
            end
        end
        checks++;
        if (mv_seen != 0 || move_valid !== 1'b0 || x !== 2'd0 || y !== 2'd0) begin
            errors++;
            $display("FAIL walled_stream: valid seen %0d times x=%0d y=%0d, need 0 0 0", mv_seen, x, y);
        end
    endtask

    task automatic test_maze_backtrack;
        int n, p0;
        blocked = 16'h2000;
        p0 = probe_n;
        start = 1'b1; tick; start = 1'b0;
        wait_valid(n);
        collect_moves(-1, -1);
        checks++;
        if (got_n != 10 || done !== 1'b1 || x !== 2'd3 || y !== 2'd3) begin
            errors++;
            $display("FAIL maze_done: got %0d moves done=%b x=%0d y=%0d, need 10 1 3 3", got_n, done, x, y);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] != exp_maze[i]) begin
                errors++;
                $display("FAIL maze_move[%0d]: got %0d, need %0d", i, got[i], exp_maze[i]);
            end
        end
        checks++;
        if (probe_n - p0 != 14) begin
            errors++;
            $display("FAIL maze_probes: got %0d, need 14", probe_n - p0);
        end
    endtask

    task automatic test_depth_fail;
        int n;
        start_s = 1'b1; tick; start_s = 1'b0;
        n = 0;
        while (!fail_s && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (fail_s !== 1'b1 || done_s !== 1'b0 || busy_s !== 1'b0 || move_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL overflow_status: fail=%b done=%b busy=%b valid=%b, need 1 0 0 0",
                     fail_s, done_s, busy_s, move_valid_s);
        end
        checks++;
        if (x_s !== 2'd1 || y_s !== 2'd3) begin
            errors++;
            $display("FAIL overflow_pos: got (%0d,%0d), need (1,3)", x_s, y_s);
        end
    endtask

    initial begin
        test_reset;
        test_open_run;
        test_replay;
        test_stall_and_start_wins;
        test_reset_mid_replay;
        test_wall_all;
        test_maze_backtrack;
        test_depth_fail;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
